attack_uart_rx: RTL
===================

// Module: attack_uart_rx
// PURPOSE
//  Receiving end of the board-to-board attack link. Deserialises 8N1 UART frames
//  sent by the peer board's transmitter and reassembles two bytes (low, then high)
//  into the 16-bit attack vector. Presents the vector with a one-cycle valid strobe
//  to the local top, where it feeds the opponent-attack register and the input checker.
// PARAMETERS
//  CLKS_PER_BIT    10417               clk cycles per UART bit (100 MHz / 9600 baud); must be >= 4
//  TIMEOUT_CYCLES  20*CLKS_PER_BIT     max idle cycles between low-byte stop and high-byte start
// PORTS
//  clk           in   1   system clock; single clock domain
//  clr           in   1   synchronous, active-high reset
//  rx            in   1   asynchronous serial line from peer board, idle high
//  attack        out  16  last complete attack word received; held until next word
//  attack_valid  out  1   one-cycle pulse when attack is updated
//  frame_err     out  1   one-cycle pulse on bad stop bit or high-byte timeout
//  busy          out  1   high while a frame is in progress or a low byte is pending
// BEHAVIOUR
//  Reset: when clr is sampled high, all state clears on that edge.
//   - attack=0, attack_valid=0, frame_err=0, busy=0, FSM=IDLE, byte pointer=LOW.
//   - Sync flops are set to 1 (idle). Reset mid-frame discards the frame and any pending low byte.
//  Input: rx passes through a 2-flop synchroniser (rx_s, reset to 1). All sampling uses rx_s.
//  Frame FSM (bit counter 0..7, baud counter 0..CLKS_PER_BIT-1):
//   - IDLE: on rx_s==0, go to START and clear the baud counter.
//   - START: at count CLKS_PER_BIT/2 (integer divide), sample rx_s.
//       0 -> go to DATA, clear the counter. 1 -> glitch; return to IDLE with no error.
//   - DATA: at count CLKS_PER_BIT-1, sample rx_s into shift bit[n], LSB first.
//       After bit 7, go to STOP.
//   - STOP: at count CLKS_PER_BIT-1, sample rx_s.
//       1 -> byte good. 0 -> framing error: pulse frame_err, discard the byte,
//       reset the byte pointer to LOW, and enter IDLE only after rx_s returns to 1.
//  Word assembly:
//   - Good byte with pointer LOW: store it in lo_byte, set pointer HIGH, start the timeout counter.
//   - Good byte with pointer HIGH: on the next clk, attack={byte,lo_byte} and attack_valid=1
//     for exactly one cycle; pointer returns to LOW.
//   - Latency: attack_valid rises 1 cycle after the high-byte stop-bit sample,
//     i.e. about 9.5 bit times plus 3 clk after the falling edge of that frame's start bit.
//   - Timeout: while pointer is HIGH and FSM is IDLE, count cycles. When the count reaches
//     TIMEOUT_CYCLES, discard lo_byte, pointer=LOW, pulse frame_err.
//     A start edge in the same cycle as expiry is still accepted as a new low byte.
//  Valid and error pulses are never asserted in the same cycle. attack never changes
//   except on an attack_valid cycle.
//  busy = (FSM != IDLE) | (pointer == HIGH).
//  Back-to-back frames (stop bit followed immediately by the next start) are accepted;
//   the FSM is in IDLE at least half a bit before the next start edge.
//  Arithmetic: counters are sized $clog2(CLKS_PER_BIT) and $clog2(TIMEOUT_CYCLES+1)
//   bits, unsigned, with no wrap inside a frame.
// TESTING  (sim with CLKS_PER_BIT=16, TIMEOUT_CYCLES=320)
//  1. Send 0x34 then 0x12 back-to-back -> one attack_valid pulse; attack=16'h1234;
//     frame_err never high.
//  2. Drive rx low for 4 clk and release -> START rejects the glitch; no valid, no
//     frame_err; busy returns to 0.
//  3. Send 0xA5 with stop bit=0 -> frame_err pulse; then send 0x01,0x80 -> attack=16'h8001.
//  4. Send low byte 0xFF, hold rx idle for 400 clk -> frame_err at 320 idle cycles;
//     attack unchanged (prior value).
//  5. Assert clr for 1 clk mid high-byte DATA, then send 0x08,0x00 -> attack=16'h0008;
//     no valid from the aborted word.
//  6. Send words 0x0001, 0x8000, 0xFFFF consecutively -> three valid pulses in order;
//     attack holds each value between pulses.

Source files
------------

// File: rtl/attack_uart_rx.sv
// Receiver for the board-to-board attack link: 8N1 UART deserialiser that pairs
// a low byte and a high byte into a 16-bit attack word with a one-cycle valid strobe.
module attack_uart_rx #(
    parameter int CLKS_PER_BIT   = 10417,
    parameter int TIMEOUT_CYCLES = 20*CLKS_PER_BIT
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        rx,
    output logic [15:0] attack,
    output logic        attack_valid,
    output logic        frame_err,
    output logic        busy
);
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam int TW = $clog2(TIMEOUT_CYCLES+1);
    localparam logic [BW-1:0] BAUD_HALF = BW'(CLKS_PER_BIT/2);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT-1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES-1);

    // S_BREAK holds off after a bad stop bit until the line returns to idle.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic          r_sync1;
    logic          r_sync2;
    logic [BW-1:0] r_baud;
    logic [2:0]    r_bit;
    logic [7:0]    r_shift;
    logic [7:0]    r_lo_byte;
    logic          r_ptr_hi;
    logic [TW-1:0] r_tmo;
    logic [15:0]   r_attack;
    logic          r_valid;
    logic          r_err;

    logic w_rx_s;
    logic w_baud_last;
    logic w_baud_mid;
    logic w_stop_good;
    logic w_stop_bad;
    logic w_tmo_expire;

    assign w_rx_s       = r_sync2;
    assign w_baud_last  = (r_baud == BAUD_LAST);
    assign w_baud_mid   = (r_baud == BAUD_HALF);
    assign w_stop_good  = (r_state == S_STOP) && w_baud_last && w_rx_s;
    assign w_stop_bad   = (r_state == S_STOP) && w_baud_last && !w_rx_s;
    assign w_tmo_expire = r_ptr_hi && (r_state == S_IDLE) && (r_tmo == TMO_LAST);

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (!w_rx_s) w_next = S_START;
            S_START: if (w_baud_mid) w_next = w_rx_s ? S_IDLE : S_DATA;
            S_DATA:  if (w_baud_last && (r_bit == 3'd7)) w_next = S_STOP;
            S_STOP:  if (w_baud_last) w_next = w_rx_s ? S_IDLE : S_BREAK;
            S_BREAK: if (w_rx_s) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy         = (r_state != S_IDLE) | r_ptr_hi;
        attack       = r_attack;
        attack_valid = r_valid;
        frame_err    = r_err;
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_baud    <= '0;
            r_bit     <= 3'd0;
            r_shift   <= 8'h00;
            r_lo_byte <= 8'h00;
            r_ptr_hi  <= 1'b0;
            r_tmo     <= '0;
            r_attack  <= 16'h0000;
            r_valid   <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_sync1 <= rx;
            r_sync2 <= r_sync1;
            r_valid <= 1'b0;
            r_err   <= 1'b0;

            // Baud counter restarts on every state change and after every data sample.
            if ((r_state != w_next) || w_baud_last || (r_state == S_IDLE) || (r_state == S_BREAK)) begin
                r_baud <= '0;
            end else begin
                r_baud <= r_baud + 1'b1;
            end

            if (r_state == S_START) begin
                r_bit <= 3'd0;
            end else if ((r_state == S_DATA) && w_baud_last) begin
                r_bit   <= r_bit + 3'd1;
                r_shift <= {w_rx_s, r_shift[7:1]};
            end

            if (w_stop_good) begin
                if (r_ptr_hi) begin
                    r_attack <= {r_shift, r_lo_byte};
                    r_valid  <= 1'b1;
                    r_ptr_hi <= 1'b0;
                end else begin
                    r_lo_byte <= r_shift;
                    r_ptr_hi  <= 1'b1;
                    r_tmo     <= '0;
                end
            end else if (w_stop_bad) begin
                r_err    <= 1'b1;
                r_ptr_hi <= 1'b0;
            end else if (w_tmo_expire) begin
                r_err    <= 1'b1;
                r_ptr_hi <= 1'b0;
                r_tmo    <= '0;
            end else if (r_ptr_hi && (r_state == S_IDLE)) begin
                r_tmo <= r_tmo + 1'b1;
            end
        end
    end
endmodule
